// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : N-channel fixed-priority / round-robin arbiter in front of the
//           single enable/valid port of the SDRAM controller, with watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req_en,
    input  logic [NCH*ADDR_W-1:0]  req_addr,
    input  logic [NCH-1:0]         req_rw,
    input  logic [2*NCH-1:0]       req_oplen,
    input  logic [NCH-1:0]         req_unsigned,
    input  logic [NCH*DATA_W-1:0]  req_wdata,
    output logic [NCH-1:0]         rsp_valid,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   m_enable,
    output logic                   m_rw,
    output logic                   m_unsigned,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [1:0]             m_oplen,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic                   m_valid,
    input  logic [DATA_W-1:0]      m_result,
    output logic [$clog2(NCH)-1:0] grant_id,
    output logic                   busy
);

    localparam int GID_W = $clog2(NCH);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit c_WDOG_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [GID_W-1:0]   r_last, w_last_nxt;

    logic [GID_W-1:0]   w_grant_nxt;
    logic               w_busy_nxt;
    logic [NCH-1:0]     w_rsp_valid_nxt;
    logic               w_rsp_err_nxt;
    logic [DATA_W-1:0]  w_rsp_data_nxt;
    logic               w_m_enable_nxt;
    logic               w_m_rw_nxt;
    logic               w_m_unsigned_nxt;
    logic [ADDR_W-1:0]  w_m_addr_nxt;
    logic [1:0]         w_m_oplen_nxt;
    logic [DATA_W-1:0]  w_m_wdata_nxt;

    int                 w_base;
    int                 w_idx;
    logic [GID_W-1:0]   w_sel;
    logic               w_found;
    logic [GID_W-1:0]   w_winner;
    logic [NCH-1:0]     w_onehot;

    // Scan from the highest offset down so the lowest offset from w_base wins.
    always_comb begin
        w_base   = 0;
        w_idx    = 0;
        w_sel    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        if (RR_MODE != 0)
            w_base = (int'(r_last) == NCH - 1) ? 0 : int'(r_last) + 1;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = w_base + k;
            if (w_idx >= NCH)
                w_idx = w_idx - NCH;
            w_sel = GID_W'(w_idx);
            if (req_en[w_sel]) begin
                w_found  = 1'b1;
                w_winner = w_sel;
            end
        end
    end

    assign w_onehot = NCH'(1) << grant_id;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_nxt       = r_last;
        w_grant_nxt      = grant_id;
        w_busy_nxt       = busy;
        w_rsp_valid_nxt  = '0;
        w_rsp_err_nxt    = rsp_err;
        w_rsp_data_nxt   = rsp_data;
        w_m_enable_nxt   = m_enable;
        w_m_rw_nxt       = m_rw;
        w_m_unsigned_nxt = m_unsigned;
        w_m_addr_nxt     = m_addr;
        w_m_oplen_nxt    = m_oplen;
        w_m_wdata_nxt    = m_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_ISSUE;
                    w_cnt_nxt        = '0;
                    w_last_nxt       = w_winner;
                    w_grant_nxt      = w_winner;
                    w_busy_nxt       = 1'b1;
                    w_m_enable_nxt   = 1'b1;
                    w_m_rw_nxt       = req_rw[w_winner];
                    w_m_unsigned_nxt = req_unsigned[w_winner];
                    w_m_addr_nxt     = req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                    w_m_oplen_nxt    = req_oplen[int'(w_winner)*2 +: 2];
                    w_m_wdata_nxt    = req_wdata[int'(w_winner)*DATA_W +: DATA_W];
                end
            end
            S_ISSUE: begin
                // A completion in the same cycle as the timeout takes precedence.
                if (m_valid) begin
                    w_state_nxt     = S_RESP;
                    w_m_enable_nxt  = 1'b0;
                    w_rsp_data_nxt  = m_result;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = req_en[grant_id] ? w_onehot : '0;
                end else if (c_WDOG_EN && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt     = S_RESP;
                    w_m_enable_nxt  = 1'b0;
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = req_en[grant_id] ? w_onehot : '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= GID_W'(NCH - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            m_enable   <= 1'b0;
            m_rw       <= 1'b0;
            m_unsigned <= 1'b0;
            m_addr     <= '0;
            m_oplen    <= '0;
            m_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            grant_id   <= w_grant_nxt;
            busy       <= w_busy_nxt;
            rsp_valid  <= w_rsp_valid_nxt;
            rsp_err    <= w_rsp_err_nxt;
            rsp_data   <= w_rsp_data_nxt;
            m_enable   <= w_m_enable_nxt;
            m_rw       <= w_m_rw_nxt;
            m_unsigned <= w_m_unsigned_nxt;
            m_addr     <= w_m_addr_nxt;
            m_oplen    <= w_m_oplen_nxt;
            m_wdata    <= w_m_wdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench: 2-ch fixed priority and 4-ch RR DUTs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]   req_en0, req_rw0, req_uns0;
    logic [49:0]  req_addr0;
    logic [3:0]   req_oplen0;
    logic [63:0]  req_wdata0;
    logic [1:0]   rsp_valid0;
    logic         rsp_err0, m_enable0, m_rw0, m_uns0, busy0;
    logic [31:0]  rsp_data0, m_wdata0, m_result0;
    logic [24:0]  m_addr0;
    logic [1:0]   m_oplen0;
    logic         m_valid0 = 1'b0;
    logic [0:0]   grant_id0;
    int           lat0 = 0, cnt0 = 0;

    logic [3:0]   req_en1, req_rw1, req_uns1;
    logic [99:0]  req_addr1;
    logic [7:0]   req_oplen1;
    logic [127:0] req_wdata1;
    logic [3:0]   rsp_valid1;
    logic         rsp_err1, m_enable1, m_rw1, m_uns1, busy1;
    logic [31:0]  rsp_data1, m_wdata1, m_result1;
    logic [24:0]  m_addr1;
    logic [1:0]   m_oplen1;
    logic         m_valid1 = 1'b0;
    logic [1:0]   grant_id1;
    int           lat1 = 0, cnt1 = 0;

    mem_arbiter #(.NCH(2), .ADDR_W(25), .DATA_W(32), .RR_MODE(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en0), .req_addr(req_addr0), .req_rw(req_rw0), .req_oplen(req_oplen0),
        .req_unsigned(req_uns0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rsp_data(rsp_data0),
        .m_enable(m_enable0), .m_rw(m_rw0), .m_unsigned(m_uns0), .m_addr(m_addr0),
        .m_oplen(m_oplen0), .m_wdata(m_wdata0), .m_valid(m_valid0), .m_result(m_result0),
        .grant_id(grant_id0), .busy(busy0)
    );

    mem_arbiter #(.NCH(4), .ADDR_W(25), .DATA_W(32), .RR_MODE(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en1), .req_addr(req_addr1), .req_rw(req_rw1), .req_oplen(req_oplen1),
        .req_unsigned(req_uns1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_data(rsp_data1),
        .m_enable(m_enable1), .m_rw(m_rw1), .m_unsigned(m_uns1), .m_addr(m_addr1),
        .m_oplen(m_oplen1), .m_wdata(m_wdata1), .m_valid(m_valid1), .m_result(m_result1),
        .grant_id(grant_id1), .busy(busy1)
    );

    // Downstream models: m_valid is high in cycle 'lat' of m_enable (lat>=2); lat=0 never answers.
    always @(posedge clk) begin
        if (!m_enable0 || m_valid0) begin
            cnt0 <= 0; m_valid0 <= 1'b0;
        end else begin
            cnt0 <= cnt0 + 1;
            if (lat0 != 0 && cnt0 + 2 == lat0) m_valid0 <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!m_enable1 || m_valid1) begin
            cnt1 <= 0; m_valid1 <= 1'b0;
        end else begin
            cnt1 <= cnt1 + 1;
            if (lat1 != 0 && cnt1 + 2 == lat1) m_valid1 <= 1'b1;
        end
    end

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_vec++; if (m_enable0 !== 1'b0) begin n_err++; $display("FAIL rst_m_enable got=%0h exp=0", m_enable0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy0); end
        n_vec++; if (rsp_valid0 !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid0); end
        n_vec++; if (rsp_data0 !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data got=%0h exp=0", rsp_data0); end
        n_vec++; if (rsp_err0 !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err got=%0h exp=0", rsp_err0); end
        n_vec++; if (m_addr0 !== 25'h0) begin n_err++; $display("FAIL rst_m_addr got=%0h exp=0", m_addr0); end
        n_vec++; if (grant_id1 !== 2'd0) begin n_err++; $display("FAIL rst_grant_id got=%0h exp=0", grant_id1); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (busy0 !== 1'b0 || m_enable1 !== 1'b0) begin n_err++; $display("FAIL idle_no_req got=%0h%0h exp=00", busy0, m_enable1); end
    endtask

    task automatic test_single_read();
        int en_cnt, n;
        bit busy_drop;
        lat0 = 4; m_result0 = 32'hDEADBEEF;
        req_addr0[24:0] = 25'h0000100; req_rw0[0] = 1'b0; req_oplen0[1:0] = 2'b10; req_uns0[0] = 1'b0;
        req_en0 = 2'b01;
        @(negedge clk);
        n_vec++; if (m_enable0 !== 1'b1) begin n_err++; $display("FAIL rd_m_enable got=%0h exp=1", m_enable0); end
        n_vec++; if (m_addr0 !== 25'h0000100) begin n_err++; $display("FAIL rd_m_addr got=%0h exp=100", m_addr0); end
        n_vec++; if (m_oplen0 !== 2'b10) begin n_err++; $display("FAIL rd_m_oplen got=%0h exp=2", m_oplen0); end
        n_vec++; if (grant_id0 !== 1'b0) begin n_err++; $display("FAIL rd_grant got=%0h exp=0", grant_id0); end
        en_cnt = 1; n = 0; busy_drop = 1'b0;
        if (busy0 !== 1'b1) busy_drop = 1'b1;
        while (rsp_valid0 === 2'b00 && n < 30) begin
            @(negedge clk); n++;
            if (busy0 !== 1'b1) busy_drop = 1'b1;
            if (m_enable0 === 1'b1) en_cnt++;
        end
        n_vec++; if (rsp_valid0 !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid got=%0h exp=1", rsp_valid0); end
        n_vec++; if (rsp_data0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rsp_data got=%0h exp=deadbeef", rsp_data0); end
        n_vec++; if (rsp_err0 !== 1'b0) begin n_err++; $display("FAIL rd_rsp_err got=%0h exp=0", rsp_err0); end
        n_vec++; if (busy_drop !== 1'b0) begin n_err++; $display("FAIL rd_busy_held got=%0h exp=0", busy_drop); end
        n_vec++; if (en_cnt != 4) begin n_err++; $display("FAIL rd_enable_cycles got=%0d exp=4", en_cnt); end
        req_en0 = 2'b00;
        @(negedge clk);
        n_vec++; if (busy0 !== 1'b0 || rsp_valid0 !== 2'b00) begin n_err++; $display("FAIL rd_idle got=%0h/%0h exp=0/0", busy0, rsp_valid0); end
    endtask

    task automatic test_priority();
        int n;
        logic exp_g;
        lat0 = 3; m_result0 = 32'h11110000;
        req_addr0[49:25] = 25'h0000400;
        req_en0 = 2'b11;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (rsp_valid0 === 2'b00 && n < 30) begin @(negedge clk); n++; end
            n_vec++; if (rsp_valid0 !== 2'b01) begin n_err++; $display("FAIL prio_rsp got=%0h exp=1", rsp_valid0); end
            n_vec++; if (grant_id0 !== 1'b0) begin n_err++; $display("FAIL prio_grant got=%0h exp=0", grant_id0); end
            if (t == 2) req_en0 = 2'b10;
            @(negedge clk);
            n_vec++; if (m_enable0 !== 1'b0) begin n_err++; $display("FAIL prio_gap got=%0h exp=0", m_enable0); end
            @(negedge clk);
            exp_g = (t == 2) ? 1'b1 : 1'b0;
            n_vec++; if (m_enable0 !== 1'b1 || grant_id0 !== exp_g) begin n_err++; $display("FAIL prio_regrant got=%0h/%0h exp=1/%0h", m_enable0, grant_id0, exp_g); end
        end
        n = 0;
        while (rsp_valid0 === 2'b00 && n < 30) begin @(negedge clk); n++; end
        n_vec++; if (rsp_valid0 !== 2'b10) begin n_err++; $display("FAIL prio_ch1_rsp got=%0h exp=2", rsp_valid0); end
        n_vec++; if (m_addr0 !== 25'h0000400) begin n_err++; $display("FAIL prio_ch1_addr got=%0h exp=400", m_addr0); end
        req_en0 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int en_cnt, n;
        lat0 = 0; req_rw0[1] = 1'b0; req_en0 = 2'b10;
        en_cnt = 0; n = 0;
        while (rsp_valid0 === 2'b00 && n < 40) begin
            @(negedge clk); n++;
            if (m_enable0 === 1'b1) en_cnt++;
        end
        n_vec++; if (en_cnt != 8) begin n_err++; $display("FAIL wd_enable_cycles got=%0d exp=8", en_cnt); end
        n_vec++; if (rsp_valid0 !== 2'b10) begin n_err++; $display("FAIL wd_rsp_valid got=%0h exp=2", rsp_valid0); end
        n_vec++; if (rsp_err0 !== 1'b1) begin n_err++; $display("FAIL wd_rsp_err got=%0h exp=1", rsp_err0); end
        n_vec++; if (rsp_data0 !== 32'h0) begin n_err++; $display("FAIL wd_rsp_data got=%0h exp=0", rsp_data0); end
        req_en0 = 2'b00;
        @(negedge clk);
        n_vec++; if (busy0 !== 1'b0 || m_enable0 !== 1'b0) begin n_err++; $display("FAIL wd_idle got=%0h/%0h exp=0/0", busy0, m_enable0); end
        lat0 = 8; m_result0 = 32'h12345678; req_en0 = 2'b01;
        en_cnt = 0; n = 0;
        while (rsp_valid0 === 2'b00 && n < 40) begin
            @(negedge clk); n++;
            if (m_enable0 === 1'b1) en_cnt++;
        end
        n_vec++; if (en_cnt != 8) begin n_err++; $display("FAIL wd_last_enable_cycles got=%0d exp=8", en_cnt); end
        n_vec++; if (rsp_valid0 !== 2'b01) begin n_err++; $display("FAIL wd_last_rsp_valid got=%0h exp=1", rsp_valid0); end
        n_vec++; if (rsp_err0 !== 1'b0) begin n_err++; $display("FAIL wd_last_rsp_err got=%0h exp=0", rsp_err0); end
        n_vec++; if (rsp_data0 !== 32'h12345678) begin n_err++; $display("FAIL wd_last_rsp_data got=%0h exp=12345678", rsp_data0); end
        req_en0 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abandon();
        int en_cnt, n;
        bit seen;
        lat0 = 6; m_result0 = 32'hA5A5A5A5;
        req_addr0[49:25] = 25'h1ABCDEF; req_wdata0[63:32] = 32'hCAFEF00D;
        req_rw0[1] = 1'b1; req_oplen0[3:2] = 2'b01; req_uns0[1] = 1'b1;
        req_en0 = 2'b10;
        @(negedge clk);
        n_vec++; if (m_enable0 !== 1'b1 || grant_id0 !== 1'b1) begin n_err++; $display("FAIL ab_grant got=%0h/%0h exp=1/1", m_enable0, grant_id0); end
        n_vec++; if (m_addr0 !== 25'h1ABCDEF) begin n_err++; $display("FAIL ab_m_addr got=%0h exp=1abcdef", m_addr0); end
        n_vec++; if (m_wdata0 !== 32'hCAFEF00D) begin n_err++; $display("FAIL ab_m_wdata got=%0h exp=cafef00d", m_wdata0); end
        n_vec++; if ({m_rw0, m_uns0, m_oplen0} !== 4'b1101) begin n_err++; $display("FAIL ab_m_ctrl got=%0h exp=d", {m_rw0, m_uns0, m_oplen0}); end
        en_cnt = 1;
        @(negedge clk);
        if (m_enable0 === 1'b1) en_cnt++;
        req_en0 = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid0 !== 2'b00) seen = 1'b1;
            if (m_enable0 === 1'b1) en_cnt++;
        end
        n_vec++; if (en_cnt != 6) begin n_err++; $display("FAIL ab_enable_cycles got=%0d exp=6", en_cnt); end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL ab_rsp_discard got=%0h exp=0", seen); end
        lat0 = 3; m_result0 = 32'h0BADF00D;
        req_addr0[24:0] = 25'h0000300; req_en0 = 2'b01;
        n = 0;
        while (rsp_valid0 === 2'b00 && n < 30) begin @(negedge clk); n++; end
        n_vec++; if (rsp_valid0 !== 2'b01) begin n_err++; $display("FAIL ab_next_rsp got=%0h exp=1", rsp_valid0); end
        n_vec++; if (rsp_data0 !== 32'h0BADF00D) begin n_err++; $display("FAIL ab_next_data got=%0h exp=badf00d", rsp_data0); end
        req_en0 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        int exp_order [10];
        logic [3:0] exp_oh;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        lat1 = 2;
        req_en1 = 4'b1111;
        for (int t = 0; t < 10; t++) begin
            m_result1 = 32'hC0DE0000 | t;
            n = 0;
            while (rsp_valid1 === 4'b0000 && n < 30) begin @(negedge clk); n++; end
            exp_oh = 4'b0001 << exp_order[t];
            n_vec++; if (rsp_valid1 !== exp_oh || grant_id1 !== 2'(exp_order[t])) begin
                n_err++; $display("FAIL rr_order[%0d] got=%0h/%0h exp=%0h/%0h", t, rsp_valid1, grant_id1, exp_oh, exp_order[t]);
            end
            n_vec++; if (rsp_data1 !== (32'hC0DE0000 | t)) begin n_err++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", t, rsp_data1, 32'hC0DE0000 | t); end
            if (t == 7) req_en1 = 4'b0101;
            @(negedge clk);
        end
        req_en1 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        lat0 = 0; lat1 = 0;
        req_en0 = 2'b10; req_en1 = 4'b0010;
        @(negedge clk);
        n_vec++; if (m_enable0 !== 1'b1 || grant_id0 !== 1'b1) begin n_err++; $display("FAIL ar_pre0 got=%0h/%0h exp=1/1", m_enable0, grant_id0); end
        n_vec++; if (m_enable1 !== 1'b1 || grant_id1 !== 2'd1) begin n_err++; $display("FAIL ar_pre1 got=%0h/%0h exp=1/1", m_enable1, grant_id1); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (m_enable0 !== 1'b0 || busy0 !== 1'b0 || rsp_valid0 !== 2'b00) begin
            n_err++; $display("FAIL ar_async0 got=%0h/%0h/%0h exp=0/0/0", m_enable0, busy0, rsp_valid0);
        end
        n_vec++; if (m_enable1 !== 1'b0 || busy1 !== 1'b0 || rsp_valid1 !== 4'b0000) begin
            n_err++; $display("FAIL ar_async1 got=%0h/%0h/%0h exp=0/0/0", m_enable1, busy1, rsp_valid1);
        end
        @(negedge clk);
        req_en0 = 2'b11; req_en1 = 4'b1111;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (m_enable0 !== 1'b1 || grant_id0 !== 1'b0) begin n_err++; $display("FAIL ar_post0 got=%0h/%0h exp=1/0", m_enable0, grant_id0); end
        n_vec++; if (m_enable1 !== 1'b1 || grant_id1 !== 2'd0) begin n_err++; $display("FAIL ar_post1 got=%0h/%0h exp=1/0", m_enable1, grant_id1); end
        req_en0 = 2'b00; req_en1 = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        req_en0 = '0; req_rw0 = '0; req_uns0 = '0; req_addr0 = '0; req_oplen0 = '0; req_wdata0 = '0;
        req_en1 = '0; req_rw1 = '0; req_uns1 = '0; req_addr1 = '0; req_oplen1 = '0; req_wdata1 = '0;
        m_result0 = '0; m_result1 = '0;
        test_reset();
        test_single_read();
        test_priority();
        test_watchdog();
        test_abandon();
        test_round_robin();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter between CPU-side memory requesters (instruction fetch, data load/store, later DMA/debug) and the single enable/valid port of `sdramController`. It generalises the fixed two-port instruction/data split into NCH channels with selectable fixed-priority or round-robin arbitration. It adds a per-transaction watchdog that returns an error response when the downstream port stalls. Sits between the core sequencer(s) and the SDRAM controller.

## Interface
- NCH, 2, number of requester channels (2..8)
- ADDR_W, 25, address width
- DATA_W, 32, data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 1024, cycles `m_enable` may stay high before abort; 0 disables the watchdog
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_en  in  NCH  per-channel request; held high, with fields stable, until `rsp_valid[i]`
- req_addr  in  NCH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- req_rw  in  NCH  0 = read, 1 = write
- req_oplen  in  2*NCH  access size, encoded as the controller's `data_oplen`
- req_unsigned  in  NCH  zero-extend on read
- req_wdata  in  NCH*DATA_W  write data
- rsp_valid  out  NCH  one-cycle completion pulse; one-hot or zero
- rsp_err  out  1  qualifies `rsp_valid`; 1 = watchdog abort
- rsp_data  out  DATA_W  read result, shared; valid only with `rsp_valid`
- m_enable, m_rw, m_unsigned  out  1  downstream request
- m_addr  out  ADDR_W
- m_oplen  out  2
- m_wdata  out  DATA_W
- m_valid  in  1  downstream completion
- m_result  in  DATA_W  downstream read data
- grant_id  out  $clog2(NCH)  index of the current or last granted channel
- busy  out  1  high in ISSUE and RESP

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_en` is set, select a winner.
  - Latch the winner's addr/rw/oplen/unsigned/wdata into the `m_*` registers, set `m_enable` = 1 and `grant_id`, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **Winner selection**
  - RR_MODE=0: lowest set index wins.
  - RR_MODE=1: first set index scanning from `(last+1) mod NCH` upward with wrap.
  - `last` updates on every grant. Reset value is NCH-1, so channel 0 wins first.
- **ISSUE**
  - `m_enable` and all `m_*` fields are held constant.
  - The timeout counter increments every cycle.
  - On `m_valid`: capture `m_result` into `rsp_data`, drop `m_enable`, go to RESP with `rsp_err` = 0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT−1 without `m_valid`: drop `m_enable`, set `rsp_data` = 0 and `rsp_err` = 1, go to RESP.
  - If `m_valid` and timeout occur in the same cycle, `m_valid` wins.
- **RESP**
  - `rsp_valid[grant_id]` = 1 for exactly this cycle, but only if `req_en[grant_id]` is still high. Otherwise the result is discarded silently.
  - Next state is IDLE. The counter clears.
- **Requester rule:** drop `req_en` on the clock edge at which `rsp_valid` is seen. A request still high in IDLE is treated as a new transaction.
- **Abandonment:** a requester dropping `req_en` during ISSUE does not abort the downstream access. The access completes and its response is discarded.
- Requests arriving during ISSUE or RESP wait. There is no queueing beyond the level-held `req_en`.
- Writes return `rsp_data` = `m_result` as delivered; requesters ignore it.

## Timing
- **Reset values (async, immediate):** FSM = IDLE; all `m_*` = 0; `rsp_valid` = 0; `rsp_err` = 0; `rsp_data` = 0; `grant_id` = 0; `busy` = 0; counter = 0; `last` = NCH-1.
- **Reset mid-transaction:** `m_enable` falls immediately and no response is generated. The SDRAM controller is reset by the same `rst_n`.
- **Latency:**
  - `req_en` sampled high in IDLE at edge k → `m_enable` high from cycle k+1.
  - `m_valid` sampled at edge j → `rsp_valid` high cycle j+1, `m_enable` low cycle j+1, IDLE at j+2.
  - Next grant is registered at edge j+2, giving `m_enable` high at j+3.
- `m_enable` is low for at least 2 cycles between transactions, which satisfies the controller's enable-low-between-requests requirement.
- **Throughput:** one transaction per (downstream latency + 3) cycles.
- All outputs are registered. There are no combinational paths from `req_*` or `m_valid` to outputs.

## Test plan
- **Single-channel read:** NCH=2, ch0 reads 0x0000100, model returns 0xDEADBEEF 3 cycles after `m_enable`. Required: `m_addr` = 0x0000100, `rsp_valid` = 2'b01, `rsp_data` = 0xDEADBEEF, `rsp_err` = 0, `busy` high throughout.
- **Fixed priority:** RR_MODE=0, ch0 and ch1 request continuously. Required: ch0 is served every time and ch1 is never granted. After ch0 drops, ch1 is granted at the next IDLE.
- **Round-robin:** RR_MODE=1, NCH=4, all channels request. Required: grant order 0,1,2,3,0; after reset the first grant goes to ch0; with only ch2 and ch0 requesting after a ch3 grant, ch0 is granted next.
- **Watchdog:** TIMEOUT=8, model never asserts `m_valid`. Required: `m_enable` high exactly 8 cycles, then `rsp_valid` on the requester with `rsp_err` = 1 and `rsp_data` = 0, then IDLE. Also check `m_valid` in the 8th cycle → normal response with `rsp_err` = 0.
- **Abandoned request:** ch1 drops `req_en` mid-ISSUE. Required: `m_enable` stays high until `m_valid`, `rsp_valid` stays 0, and the next grant proceeds normally.
- **Async reset:** assert `rst_n` low while `m_enable` is high. Required: `m_enable`, `busy` and `rsp_valid` are 0 before the next clock edge. After release, ch0 is granted first.
